prog_mem_loadable: RTL

//  Parametrised, run-time loadable instruction memory for the uProcessor core.

---
 rtl/upm_pkg.sv | 28 ++
 rtl/pm_word_assembler.sv | 69 ++++++
 rtl/prog_mem_loadable.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/upm_pkg.sv
// Shared definitions for the uProcessor program memory.
//  - Opcode constants and the default instruction width.
//  - NOP_WORD: the word returned for unwritten, blocked or reset reads.
//  - ld_state_t: states of the byte-stream load FSM.
//  - bytes_per_word(): number of load bytes per instruction word.
package upm_pkg;

   localparam int INS_W_DEF = 13;
   localparam int OPCODE_W  = INS_W_DEF - 8;

   localparam logic [OPCODE_W-1:0] OPCODE_NOP = 5'h1E;
   localparam logic [OPCODE_W-1:0] OPCODE_LDI = 5'h01;
   localparam logic [OPCODE_W-1:0] OPCODE_JMP = 5'h10;

   localparam logic [INS_W_DEF-1:0] NOP_WORD = {OPCODE_NOP, 8'h00};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      COMMIT = 2'd2
   } ld_state_t;

   // Number of bytes needed to carry one instruction word (ceil(w/8)).
   function automatic int bytes_per_word(input int w);
      return (w + 7) / 8;
   endfunction

endpackage

// File: rtl/pm_word_assembler.sv
// Assembles LSB-first load bytes into one instruction word.
// Ports:
//  clk, rst       clock and asynchronous active-high reset
//  clr_i          return the byte counter to 0 (loader idle)
//  beat_i         one byte accepted this cycle (valid & ready)
//  data_i         the byte being accepted
//  word_o         assembled word; bits at or above INS_W are dropped
//  word_ready_o   this beat carries the last byte of the word
module pm_word_assembler
   import upm_pkg::*;
#(
   parameter int INS_W = INS_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             beat_i,
   input  logic [7:0]       data_i,
   output logic [INS_W-1:0] word_o,
   output logic             word_ready_o
);

   localparam int BYTES = bytes_per_word(INS_W);
   localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int SR_W  = 8 * BYTES;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [SR_W-1:0]  shift_q, shift_d;

   // Next-state logic: new bytes enter at the top so byte k lands at [8k+7:8k].
   always_comb begin
      byte_cnt_d   = byte_cnt_q;
      shift_d      = shift_q;
      word_ready_o = beat_i && (byte_cnt_q == LAST_CNT);
      if (clr_i) begin
         byte_cnt_d = CNT_ZERO;
      end else if (beat_i) begin
         shift_d    = (shift_q >> 8) | (SR_W'(data_i) << (SR_W - 8));
         byte_cnt_d = word_ready_o ? CNT_ZERO : (byte_cnt_q + CNT_ONE);
      end else begin
         byte_cnt_d = byte_cnt_q;
      end
   end

   // Byte counter and assembly register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt_q <= CNT_ZERO;
         shift_q    <= {SR_W{1'b0}};
      end else begin
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
      end
   end

   assign word_o = shift_q[INS_W-1:0];

   generate
      if (SR_W > INS_W) begin : g_drop
         // Padding bits beyond the instruction width are intentionally discarded.
         logic unused_pad_s;
         assign unused_pad_s = ^shift_q[SR_W-1:INS_W];
      end
   endgenerate

endmodule

// File: rtl/prog_mem_loadable.sv
// Run-time loadable instruction memory with a registered fetch port.
// Ports:
//  clk, rst           clock and asynchronous active-high reset
//  fetch_en_i/addr_i  fetch request; answered one cycle later on ins_out_o/ins_valid_o
//  busy_o             a load is in progress; fetches return NOP_WORD
//  ld_start_i         start a load of ld_len_i words at ld_base_i (ignored while busy)
//  ld_data_i/valid_i  byte stream, LSB-first within each word
//  ld_ready_o         byte accepted this cycle when ld_valid_i is also high
//  ld_done_o          one-cycle pulse after the last word is committed
module prog_mem_loadable
   import upm_pkg::*;
#(
   parameter int               INS_W    = INS_W_DEF,
   parameter int               ADDR_W   = 5,
   parameter logic [INS_W-1:0] NOP_WORD = upm_pkg::NOP_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   output logic [INS_W-1:0]  ins_out_o,
   output logic              ins_valid_o,
   output logic              busy_o,
   input  logic              ld_start_i,
   input  logic [ADDR_W-1:0] ld_base_i,
   input  logic [ADDR_W:0]   ld_len_i,
   input  logic [7:0]        ld_data_i,
   input  logic              ld_valid_i,
   output logic              ld_ready_o,
   output logic              ld_done_o
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]   LEN_ZERO  = (ADDR_W + 1)'(0);
   localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   ld_state_t         state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   rem_q;
   logic              ld_done_q;
   logic [DEPTH-1:0]  valid_q;
   logic [INS_W-1:0]  mem_q [DEPTH];
   logic [INS_W-1:0]  ins_q;
   logic              ins_valid_q;

   logic              beat_s;
   logic              word_ready_s;
   logic [INS_W-1:0]  word_s;

   assign busy_o     = (state_q != IDLE);
   assign ld_ready_o = (state_q == RECV);
   assign beat_s     = ld_valid_i && ld_ready_o;

   pm_word_assembler #(
      .INS_W (INS_W)
   ) u_asm (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (state_q == IDLE),
      .beat_i       (beat_s),
      .data_i       (ld_data_i),
      .word_o       (word_s),
      .word_ready_o (word_ready_s)
   );

   // Load FSM with its address/length counters and the done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= ADDR_ZERO;
         rem_q     <= LEN_ZERO;
         ld_done_q <= 1'b0;
      end else begin
         ld_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A zero-length request is a silent no-op.
               if (ld_start_i && (ld_len_i != LEN_ZERO)) begin
                  addr_q  <= ld_base_i;
                  rem_q   <= ld_len_i;
                  state_q <= RECV;
               end
            end
            RECV: begin
               if (word_ready_s) begin
                  state_q <= COMMIT;
               end
            end
            COMMIT: begin
               // Address wraps modulo DEPTH; overlong loads overwrite their own start.
               addr_q <= addr_q + ADDR_ONE;
               rem_q  <= rem_q - LEN_ONE;
               if (rem_q == LEN_ONE) begin
                  state_q   <= IDLE;
                  ld_done_q <= 1'b1;
               end else begin
                  state_q <= RECV;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Instruction storage; left unreset so it maps onto a RAM.
   always_ff @(posedge clk) begin
      if (state_q == COMMIT) begin
         mem_q[addr_q] <= word_s;
      end
   end

   // Per-word written flags; cleared by reset so unwritten words read as NOP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= {DEPTH{1'b0}};
      end else if (state_q == COMMIT) begin
         valid_q[addr_q] <= 1'b1;
      end
   end

   // Registered fetch port; blocked while loading so there is no read/write hazard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ins_q       <= NOP_WORD;
         ins_valid_q <= 1'b0;
      end else begin
         ins_valid_q <= fetch_en_i;
         if (fetch_en_i) begin
            if (!busy_o && valid_q[fetch_addr_i]) begin
               ins_q <= mem_q[fetch_addr_i];
            end else begin
               ins_q <= NOP_WORD;
            end
         end
      end
   end

   assign ins_out_o   = ins_q;
   assign ins_valid_o = ins_valid_q;
   assign ld_done_o   = ld_done_q;

endmodule
